csr_enc_hls_deadlock_monitor_param: RTL and testbench
=====================================================

# csr_enc_hls_deadlock_monitor_param

Parametrised deadlock monitor for the csr_enc HLS datapath, one instance per sequential region (e.g. the inputMatrix subroutine). It combines masked AXIS-stall flags and per-instance block flags from child monitors into a raw stall condition. `block` asserts only after that condition persists for a programmable number of cycles, and the block records which source caused the deadlock. Its output feeds the parent monitor's `inst_block_sigs` bit, so monitors nest into a tree.

## Interface
- `AXIS_W`, 4: number of AXIS stall flags.
- `N_INST`, 1: number of child instances (idle/block pairs).
- `AXIS_MASK`, {AXIS_W{1'b1}}: selects which AXIS flags count toward a stall.
- `INST_MASK`, {N_INST{1'b1}}: selects which child block flags count.
- `THRESH`, 16: consecutive stalled cycles required; legal range 1..65535.
- `CNT_W`, 16: width of the persistence counter.
- `EVT_W`, 8: width of the deadlock event counter.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `axis_block_sigs`  in  AXIS_W  per-channel AXIS stall flags.
- `inst_idle_sigs`  in  N_INST  per-child idle flags.
- `inst_block_sigs`  in  N_INST  per-child block outputs.
- `clear`  in  1  synchronous clear of the detection state.
- `block`  out  1  deadlock detected (registered).
- `block_cause`  out  AXIS_W+N_INST  sources active at detection; {inst, axis}, axis in the LSBs.
- `block_events`  out  EVT_W  saturating count of entries into BLOCKED.

## Operation
- `axis_hit` = `axis_block_sigs` & `AXIS_MASK`.
- `inst_hit` = `inst_block_sigs` & ~`inst_idle_sigs` & `INST_MASK`. An idle child never contributes.
- `raw` = |`axis_hit` | |`inst_hit`. This signal is combinational and internal only.
- FSM states are IDLE, SUSPECT and BLOCKED. A CNT_W-bit counter `cnt` tracks consecutive stalled cycles.
- IDLE:
  - `raw`=1 with THRESH=1: go to BLOCKED.
  - `raw`=1 otherwise: go to SUSPECT with `cnt`=1.
  - `raw`=0: stay in IDLE.
- SUSPECT:
  - `raw`=0: go to IDLE with `cnt`=0.
  - `raw`=1 and `cnt`+1 == THRESH: go to BLOCKED.
  - `raw`=1 otherwise: `cnt`++.
- BLOCKED:
  - `raw`=0: go to IDLE with `cnt`=0 (non-sticky build only; see Configuration).
  - `raw`=1: stay in BLOCKED.
- On entry to BLOCKED:
  - `block_cause` ← {`inst_hit`, `axis_hit`} as sampled on the entry edge.
  - `block_events` increments and saturates at 2^EVT_W−1.
- `block_cause` holds its value until the next entry to BLOCKED or until `clear`.
- `clear`=1 takes priority over every transition on that edge:
  - state → IDLE, `cnt` → 0, `block_cause` → 0.
  - `block_events` is not affected.
- `cnt` never exceeds THRESH−1.

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE, `cnt`=0, `block`=0, `block_cause`=0, `block_events`=0.
- `block` is a registered decode of state==BLOCKED.
- `block` rises on the THRESH-th consecutive edge that samples `raw`=1.
  - THRESH=1 gives a one-cycle register delay.
- `block` falls on the first edge that samples `raw`=0 (non-sticky) or `clear`=1.
- Stall reappearing while leaving BLOCKED: if `raw` drops for exactly one cycle, the sequence restarts from IDLE and needs THRESH more edges. There is no hysteresis.
- Reset asserted mid-count or while BLOCKED: all state clears immediately. Counting resumes from 0 on the first edge after `reset_n` rises.

## Configuration
- `CSR_ENC_DEADLOCK_STICKY_EN` defined:
  - BLOCKED ignores `raw`=0.
  - `block` stays at 1 until `clear` or reset, so a transient deadlock is held for the debug readout.
- Macro undefined: BLOCKED exits to IDLE whenever `raw`=0, as described in Operation.

## Test plan
- Persistence and release:
  - Stimulus: THRESH=4, `axis_block_sigs`=4'b0010 held.
  - Required: `block` rises on the 4th edge, `block_cause`=5'b00010, `block_events`=1.
  - Then drop the flag: `block`=0 one edge later (non-sticky).
- Glitch rejection: THRESH=4, `raw` high for 3 edges, low for 1, high for 4 → `block` rises only on the 8th edge; `block_events`=1.
- Masking:
  - Stimulus: AXIS_MASK=4'b1101, `axis_block_sigs`=4'b0010 for 100 cycles.
  - Required: `block` stays 0.
  - Then `inst_block_sigs`=1 with `inst_idle_sigs`=1 → `block` stays 0.
  - Then `inst_idle_sigs`=0 → `block` rises after THRESH edges, `block_cause`=5'b10000.
- Sticky build:
  - Stimulus: `CSR_ENC_DEADLOCK_STICKY_EN` defined, THRESH=2, stall for 2 edges, then `raw`=0 for 10 edges.
  - Required: `block` stays 1.
  - Pulse `clear` → `block`=0 and `block_cause`=0 next edge, `block_events` unchanged.
- Clear/reset priority:
  - Stimulus: `clear`=1 on the same edge `cnt` would reach THRESH.
  - Required: `block` stays 0 and `cnt`=0.
  - Separately: assert `reset_n`=0 mid-BLOCKED → `block`, `block_cause` and `block_events` go to 0 without waiting for a clock edge.
- Event saturation: EVT_W=2, five separate deadlocks → `block_events`=3.

Source files
------------

// File: rtl/csr_enc_hls_deadlock_monitor_param.sv
// rtl/csr_enc_hls_deadlock_monitor_param.sv - persistence-filtered deadlock monitor node for the csr_enc HLS monitor tree
// Optional: CSR_ENC_DEADLOCK_STICKY_EN holds block until clear or reset.
module csr_enc_hls_deadlock_monitor_param #(
    parameter int                AXIS_W    = 4,
    parameter int                N_INST    = 1,
    parameter logic [AXIS_W-1:0] AXIS_MASK = {AXIS_W{1'b1}},
    parameter logic [N_INST-1:0] INST_MASK = {N_INST{1'b1}},
    parameter int                THRESH    = 16,
    parameter int                CNT_W     = 16,
    parameter int                EVT_W     = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [AXIS_W-1:0]        axis_block_sigs,
    input  logic [N_INST-1:0]        inst_idle_sigs,
    input  logic [N_INST-1:0]        inst_block_sigs,
    input  logic                     clear,
    output logic                     block,
    output logic [AXIS_W+N_INST-1:0] block_cause,
    output logic [EVT_W-1:0]         block_events
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W:0] LP_THRESH = (CNT_W+1)'(THRESH);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_block;
    logic [AXIS_W+N_INST-1:0]  r_block_cause;
    logic [EVT_W-1:0]          r_block_events;

    logic [AXIS_W-1:0]         w_axis_hit;
    logic [N_INST-1:0]         w_inst_hit;
    logic                      w_raw;
    logic [CNT_W:0]            w_cnt_inc;
    logic                      w_enter;

    // An idle child cannot be the reason its parent is stuck.
    assign w_axis_hit = axis_block_sigs & AXIS_MASK;
    assign w_inst_hit = inst_block_sigs & ~inst_idle_sigs & INST_MASK;
    assign w_raw      = (|w_axis_hit) | (|w_inst_hit);
    assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_enter    = w_raw &&
                        (((r_state == ST_IDLE) && (THRESH == 1)) ||
                         ((r_state == ST_SUSPECT) && (w_cnt_inc == LP_THRESH)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_block        <= 1'b0;
            r_block_cause  <= '0;
            r_block_events <= '0;
        end else if (clear) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_block       <= 1'b0;
            r_block_cause <= '0;
        end else if (w_enter) begin
            r_state       <= ST_BLOCKED;
            r_cnt         <= '0;
            r_block       <= 1'b1;
            r_block_cause <= {w_inst_hit, w_axis_hit};
            if (r_block_events != {EVT_W{1'b1}}) begin
                r_block_events <= r_block_events + EVT_W'(1);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_raw) begin
                        r_state <= ST_SUSPECT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_SUSPECT: begin
                    if (!w_raw) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_BLOCKED: begin
`ifdef CSR_ENC_DEADLOCK_STICKY_EN
                    r_state <= ST_BLOCKED;
`else
                    if (!w_raw) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_block <= 1'b0;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_block <= 1'b0;
                end
            endcase
        end
    end

    assign block        = r_block;
    assign block_cause  = r_block_cause;
    assign block_events = r_block_events;

endmodule

// File: tb/tb_csr_enc_hls_deadlock_monitor_param.sv
// tb/tb_csr_enc_hls_deadlock_monitor_param.sv - directed self-checking bench for the deadlock monitor
module tb_csr_enc_hls_deadlock_monitor_param;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic [3:0] a_axis = '0, m_axis = '0, s_axis = '0;
    logic [0:0] a_idle = '0, m_idle = '0, s_idle = '0;
    logic [0:0] a_inst = '0, m_inst = '0, s_inst = '0;
    logic       a_clear = 1'b0, m_clear = 1'b0, s_clear = 1'b0;
    logic       a_block, m_block, s_block;
    logic [4:0] a_cause, m_cause, s_cause;
    logic [7:0] a_events, m_events;
    logic [1:0] s_events;

    always #5 clock = ~clock;

    csr_enc_hls_deadlock_monitor_param #(.THRESH(4)) u_a (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(a_axis),
        .inst_idle_sigs(a_idle), .inst_block_sigs(a_inst), .clear(a_clear),
        .block(a_block), .block_cause(a_cause), .block_events(a_events));

    csr_enc_hls_deadlock_monitor_param #(.AXIS_MASK(4'b1101), .THRESH(4)) u_m (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(m_axis),
        .inst_idle_sigs(m_idle), .inst_block_sigs(m_inst), .clear(m_clear),
        .block(m_block), .block_cause(m_cause), .block_events(m_events));

    csr_enc_hls_deadlock_monitor_param #(.THRESH(2), .EVT_W(2)) u_s (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(s_axis),
        .inst_idle_sigs(s_idle), .inst_block_sigs(s_inst), .clear(s_clear),
        .block(s_block), .block_cause(s_cause), .block_events(s_events));

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        a_axis = '0; m_axis = '0; s_axis = '0;
        a_inst = '0; m_inst = '0; s_inst = '0;
        a_idle = '0; m_idle = '0; s_idle = '0;
        a_clear = 1'b0; m_clear = 1'b0; s_clear = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_block, a_cause, a_events} !== 14'h0) begin
            errors++;
            $display("FAIL reset_state got %0h exp 0", {a_block, a_cause, a_events});
        end
    endtask

    task automatic test_persistence();
        do_reset();
        a_axis = 4'b0010;
        tick(3);
        checks++;
        if (a_block !== 1'b0) begin errors++; $display("FAIL persist_edge3 got %0b exp 0", a_block); end
        tick(1);
        checks++;
        if (a_block !== 1'b1) begin errors++; $display("FAIL persist_edge4 got %0b exp 1", a_block); end
        checks++;
        if (a_cause !== 5'b00010) begin errors++; $display("FAIL persist_cause got %05b exp 00010", a_cause); end
        checks++;
        if (a_events !== 8'd1) begin errors++; $display("FAIL persist_events got %0d exp 1", a_events); end
        a_axis = 4'b0000;
        tick(1);
        checks++;
        if (a_block !== 1'b0) begin errors++; $display("FAIL release got %0b exp 0", a_block); end
        checks++;
        if (a_cause !== 5'b00010) begin errors++; $display("FAIL cause_hold got %05b exp 00010", a_cause); end
    endtask

    task automatic test_glitch();
        do_reset();
        a_axis = 4'b0001;
        tick(3);
        a_axis = 4'b0000;
        tick(1);
        a_axis = 4'b1000;
        tick(3);
        checks++;
        if (a_block !== 1'b0) begin errors++; $display("FAIL glitch_edge7 got %0b exp 0", a_block); end
        tick(1);
        checks++;
        if (a_block !== 1'b1) begin errors++; $display("FAIL glitch_edge8 got %0b exp 1", a_block); end
        checks++;
        if (a_events !== 8'd1) begin errors++; $display("FAIL glitch_events got %0d exp 1", a_events); end
        checks++;
        if (a_cause !== 5'b01000) begin errors++; $display("FAIL glitch_cause got %05b exp 01000", a_cause); end
    endtask

    task automatic test_masking();
        int seen;
        do_reset();
        seen = 0;
        m_axis = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (m_block !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mask_axis got %0d exp 0", seen); end
        m_inst = 1'b1;
        m_idle = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (m_block !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mask_idle got %0d exp 0", seen); end
        m_idle = 1'b0;
        tick(3);
        checks++;
        if (m_block !== 1'b0) begin errors++; $display("FAIL mask_inst_edge3 got %0b exp 0", m_block); end
        tick(1);
        checks++;
        if (m_block !== 1'b1) begin errors++; $display("FAIL mask_inst_edge4 got %0b exp 1", m_block); end
        checks++;
        if (m_cause !== 5'b10000) begin errors++; $display("FAIL mask_cause got %05b exp 10000", m_cause); end
    endtask

    task automatic test_sticky();
        do_reset();
        s_axis = 4'b0001;
        tick(2);
        checks++;
        if (s_block !== 1'b1) begin errors++; $display("FAIL sticky_enter got %0b exp 1", s_block); end
        s_axis = 4'b0000;
        tick(10);
        checks++;
`ifdef CSR_ENC_DEADLOCK_STICKY_EN
        if (s_block !== 1'b1) begin errors++; $display("FAIL sticky_hold got %0b exp 1", s_block); end
`else
        if (s_block !== 1'b0) begin errors++; $display("FAIL nonsticky_drop got %0b exp 0", s_block); end
`endif
        checks++;
        if (s_cause !== 5'b00001) begin errors++; $display("FAIL sticky_cause got %05b exp 00001", s_cause); end
        s_clear = 1'b1;
        tick(1);
        s_clear = 1'b0;
        checks++;
        if ({s_block, s_cause} !== 6'b0) begin errors++; $display("FAIL sticky_clear got %06b exp 000000", {s_block, s_cause}); end
        checks++;
        if (s_events !== 2'd1) begin errors++; $display("FAIL sticky_events got %0d exp 1", s_events); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        a_axis = 4'b0100;
        tick(3);
        a_clear = 1'b1;
        tick(1);
        a_clear = 1'b0;
        checks++;
        if (a_block !== 1'b0) begin errors++; $display("FAIL clear_prio_block got %0b exp 0", a_block); end
        checks++;
        if (u_a.r_cnt !== 16'd0) begin errors++; $display("FAIL clear_prio_cnt got %0d exp 0", u_a.r_cnt); end
        tick(1);
        checks++;
        if (u_a.r_cnt !== 16'd1) begin errors++; $display("FAIL clear_restart_cnt got %0d exp 1", u_a.r_cnt); end
        tick(3);
        checks++;
        if (a_block !== 1'b1) begin errors++; $display("FAIL clear_reblock got %0b exp 1", a_block); end
        a_clear = 1'b1;
        tick(1);
        a_clear = 1'b0;
        checks++;
        if ({a_block, a_cause, a_events} !== {1'b0, 5'b0, 8'd1}) begin
            errors++;
            $display("FAIL clear_blocked got %0h exp %0h", {a_block, a_cause, a_events}, {1'b0, 5'b0, 8'd1});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        a_axis = 4'b0001;
        tick(4);
        checks++;
        if (a_block !== 1'b1) begin errors++; $display("FAIL pre_reset_block got %0b exp 1", a_block); end
        reset_n = 1'b0;
        #2;
        checks++;
        if ({a_block, a_cause, a_events} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset got %0h exp 0", {a_block, a_cause, a_events});
        end
        tick(1);
        reset_n = 1'b1;
        tick(3);
        checks++;
        if (a_block !== 1'b0) begin errors++; $display("FAIL post_reset_edge3 got %0b exp 0", a_block); end
        tick(1);
        checks++;
        if (a_block !== 1'b1) begin errors++; $display("FAIL post_reset_edge4 got %0b exp 1", a_block); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_ev;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s_axis = 4'b0010;
            tick(2);
            checks++;
            if (s_block !== 1'b1) begin errors++; $display("FAIL sat_block%0d got %0b exp 1", i, s_block); end
            exp_ev = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (s_events !== exp_ev) begin errors++; $display("FAIL sat_events%0d got %0d exp %0d", i, s_events, exp_ev); end
            s_axis = 4'b0000;
            s_clear = 1'b1;
            tick(1);
            s_clear = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_persistence();
        test_glitch();
        test_masking();
        test_sticky();
        test_clear_priority();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
